// File: rtl/mmu_fifo_seq.sv
// rtl/mmu_fifo_seq.sv - load/skewed-drain sequencer for the systolic array row FIFOs
// Optional protocol checking (full/empty gating, sticky err_o) under `FIFO_SEQ_ERRCHK_EN.
module mmu_fifo_seq #(
    parameter int  NUM_ROW    = 8,
    parameter int  FIFO_DEPTH = 8,
    localparam int LEN_W      = $clog2(FIFO_DEPTH) + 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + NUM_ROW) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [NUM_ROW-1:0] full_i,
    input  logic [NUM_ROW-1:0] empty_i,
    output logic [NUM_ROW-1:0] wren_o,
    output logic [NUM_ROW-1:0] rden_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(FIFO_DEPTH);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]   t_q, t_d;
    logic               err_q, err_d;
    logic [NUM_ROW-1:0] sched;
    logic [CNT_W-1:0]   drain_end;
    logic               load_ok;

`ifdef FIFO_SEQ_ERRCHK_EN
    assign load_ok = ~|full_i;
`else
    logic unused_flags;
    assign unused_flags = ^{full_i, empty_i};
    assign load_ok      = 1'b1;
`endif

    // Row r is read while r <= t < r+len: the diagonal wavefront skew.
    always_comb begin
        sched = '0;
        for (int r = 0; r < NUM_ROW; r++) begin
            sched[r] = (int'(t_q) >= r) && (int'(t_q) < r + int'(len_q));
        end
    end

    // DRAIN covers t = 0 .. len+NUM_ROW-2; written this way to stay valid for NUM_ROW=1.
    assign drain_end = CNT_W'(len_q) + CNT_W'(NUM_ROW - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            load_cnt_q <= '0;
            t_q        <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            load_cnt_q <= load_cnt_d;
            t_q        <= t_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        err_d      = err_q;
        in_ready_o = 1'b0;
        wren_o     = '0;
        rden_o     = '0;
        done_o     = 1'b0;
        busy_o     = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start_i && (len_i != '0)) begin
                    if (len_i > DEPTH_L) begin
`ifdef FIFO_SEQ_ERRCHK_EN
                        err_d = 1'b1;
`else
                        len_d      = DEPTH_L;
                        load_cnt_d = '0;
                        state_d    = S_LOAD;
`endif
                    end else begin
                        len_d      = len_i;
                        load_cnt_d = '0;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                in_ready_o = load_ok;
                if (in_valid_i && load_ok) begin
                    wren_o     = '1;
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_d == len_q) begin
                        state_d = S_DRAIN;
                        t_d     = '0;
                    end
                end
            end
            S_DRAIN: begin
                t_d = t_q + 1'b1;
`ifdef FIFO_SEQ_ERRCHK_EN
                rden_o = sched & ~empty_i;
                if (|(sched & empty_i)) begin
                    err_d = 1'b1;
                end
`else
                rden_o = sched;
`endif
                if (t_d == drain_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_mmu_fifo_seq.sv
// tb/tb_mmu_fifo_seq.sv - randomized self-checking bench for mmu_fifo_seq against a tile timeline model
module tb_mmu_fifo_seq;

    localparam int NR    = 4;
    localparam int DEPTH = 8;
    localparam int LEN_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [LEN_W-1:0]  len_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [NR-1:0]     full_i;
    logic [NR-1:0]     empty_i;
    logic [NR-1:0]     wren_o;
    logic [NR-1:0]     rden_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic err_m = 1'b0;

    always #5 clk = ~clk;

    mmu_fifo_seq #(.NUM_ROW(NR), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .len_i     (len_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .full_i    (full_i),
        .empty_i   (empty_i),
        .wren_o    (wren_o),
        .rden_o    (rden_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // The error-check build sees clean flags except the forced empty mask; the plain build must ignore any flags.
    task automatic drive_flags(input logic [NR-1:0] emask);
`ifdef FIFO_SEQ_ERRCHK_EN
        full_i  = '0;
        empty_i = emask;
`else
        full_i  = NR'($urandom);
        empty_i = NR'($urandom) | emask;
`endif
    endtask

    // One tile: start at local cycle 0, writes on accepted valids, row r reads len cycles from D+r, done at D+len+NR-1.
    task automatic run_tile(input int len_req, input int pct, input logic [63:0] holes,
                            input logic [NR-1:0] emask, input int abort_c);
        int      eff, L, D, dc, cnt, k;
        bit      ign, eset, gated, exp_ready;
        bit      vld[128];
        logic [NR-1:0] exp_wren, exp_rd;

        ign = 0; eset = 0; eff = len_req;
        if (len_req == 0) ign = 1;
        else if (len_req > DEPTH) begin
`ifdef FIFO_SEQ_ERRCHK_EN
            ign = 1; eset = 1;
`else
            eff = DEPTH;
`endif
        end

        if (ign) begin
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                start_i    = (c == 0);
                len_i      = LEN_W'(len_req);
                in_valid_i = 1'($urandom_range(1));
                drive_flags('0);
                @(negedge clk);
                check_val("idle_busy",  32'(busy_o),     32'(0));
                check_val("idle_ready", 32'(in_ready_o), 32'(0));
                check_val("idle_wren",  32'(wren_o),     32'(0));
                check_val("idle_err",   32'(err_o),      32'(err_m));
                if (c == 0 && eset) err_m = 1'b1;
            end
            start_i = 1'b0;
            return;
        end

        for (int i = 0; i < 128; i++) vld[i] = 0;
        cnt = 0; k = 1; L = 0;
        while (cnt < eff) begin
            vld[k] = !holes[k] && ((k > 40) || ($urandom_range(99) < pct));
            if (vld[k]) begin cnt++; L = k; end
            k++;
        end
        D  = L + 1;
        dc = D + eff + NR - 1;

        for (int c = 0; c <= dc + 1; c++) begin
            @(posedge clk); #1;
            start_i    = (c == 0) ? 1'b1 : ((c <= dc) ? 1'($urandom_range(1)) : 1'b0);
            len_i      = (c == 0) ? LEN_W'(len_req) : LEN_W'($urandom);
            in_valid_i = (c >= 1 && c <= L) ? vld[c] : 1'($urandom_range(1));
            drive_flags((c >= D && c < dc) ? emask : '0);

            exp_ready = (c >= 1 && c <= L);
            exp_wren  = (exp_ready && vld[c]) ? '1 : '0;
            gated     = 0;
            for (int r = 0; r < NR; r++) begin
                bit sch;
                sch = (c >= D + r) && (c < D + r + eff);
`ifdef FIFO_SEQ_ERRCHK_EN
                exp_rd[r] = sch && !emask[r];
                if (sch && emask[r]) gated = 1;
`else
                exp_rd[r] = sch;
`endif
            end

            if (c == abort_c) begin
                #1 rst_n = 1'b0;
                #1;
                check_val("abort_rden",  32'(rden_o),     32'(0));
                check_val("abort_busy",  32'(busy_o),     32'(0));
                check_val("abort_wren",  32'(wren_o),     32'(0));
                check_val("abort_ready", 32'(in_ready_o), 32'(0));
                check_val("abort_done",  32'(done_o),     32'(0));
                check_val("abort_err",   32'(err_o),      32'(0));
                err_m = 1'b0;
                @(negedge clk);
                rst_n   = 1'b1;
                start_i = 1'b0;
                return;
            end

            @(negedge clk);
            check_val("ready", 32'(in_ready_o), 32'(exp_ready));
            check_val("wren",  32'(wren_o),     32'(exp_wren));
            check_val("rden",  32'(rden_o),     32'(exp_rd));
            check_val("busy",  32'(busy_o),     32'(c >= 1 && c <= dc));
            check_val("done",  32'(done_o),     32'(c == dc));
            check_val("err",   32'(err_o),      32'(err_m));
            if (gated) err_m = 1'b1;
        end
        start_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_i = 1'b0; len_i = '0; in_valid_i = 1'b0;
        full_i = '0; empty_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_val("rst_outs", 32'({in_ready_o, wren_o, rden_o, done_o, err_o}), 32'(0));
            check_val("rst_busy", 32'(busy_o), 32'(0));
        end

        run_tile(3, 100, 64'h0, '0, -1);
        run_tile(3, 100, 64'hC, '0, -1);
        run_tile(0, 100, 64'h0, '0, -1);
        run_tile(9, 100, 64'h0, '0, -1);
`ifdef FIFO_SEQ_ERRCHK_EN
        run_tile(3, 100, 64'h0, 4'b0100, -1);
`endif
        run_tile(3, 100, 64'h0, '0, 5);
        run_tile(1, 100, 64'h0, '0, -1);
        run_tile(8, 100, 64'h0, '0, -1);

        for (int t = 0; t < 60; t++) begin
            logic [NR-1:0] em;
            em = ($urandom_range(7) == 0) ? NR'($urandom) : '0;
            run_tile($urandom_range(12), $urandom_range(30, 100), 64'h0, em, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
